mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: arbitrates N line-cache ports onto one cacheline adapter, one transaction at a time.
// Build option MEM_ARBITER_RR_EN selects round-robin grants; without it the lowest-index requester wins.
module mem_arbiter_rr #(
  parameter int N_PORTS = 2,
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_read_i,
  input  logic [N_PORTS-1:0]        req_write_i,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [N_PORTS*LINE_W-1:0] req_wdata_i,
  output logic [LINE_W-1:0]         req_rdata_o,
  output logic [N_PORTS-1:0]        req_resp_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [LINE_W-1:0]         mem_wdata_o,
  input  logic [LINE_W-1:0]         mem_rdata_i,
  input  logic                      mem_resp_i
);
  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic [PTR_W-1:0]   grant_r, grant_nxt_s;
  logic               mem_read_r, mem_read_nxt_s;
  logic               mem_write_r, mem_write_nxt_s;
  logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
  logic [LINE_W-1:0]  wdata_r, wdata_nxt_s;
  logic [LINE_W-1:0]  rdata_r, rdata_nxt_s;
  logic [N_PORTS-1:0] resp_r, resp_nxt_s;
`ifdef MEM_ARBITER_RR_EN
  logic [PTR_W-1:0]   ptr_r, ptr_nxt_s;
`endif

  logic [N_PORTS-1:0] req_any_s;
  logic               any_req_s;
  int                 cand_s;
  logic [PTR_W-1:0]   sel_s;
  logic               sel_write_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [LINE_W-1:0]  sel_wdata_s;
  logic [N_PORTS-1:0] grant_onehot_s;

  // Grant selection: scanning from the far end leaves the first requester in search order as winner.
  always_comb begin
    req_any_s = req_read_i | req_write_i;
    any_req_s = |req_any_s;
    sel_s     = '0;
    cand_s    = 0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
`ifdef MEM_ARBITER_RR_EN
      cand_s = (int'(ptr_r) + k >= N_PORTS) ? int'(ptr_r) + k - N_PORTS : int'(ptr_r) + k;
`else
      cand_s = k;
`endif
      sel_s = req_any_s[cand_s] ? PTR_W'(cand_s) : sel_s;
    end
    sel_write_s    = 1'b0;
    sel_addr_s     = '0;
    sel_wdata_s    = '0;
    grant_onehot_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      sel_write_s       = (sel_s == PTR_W'(i)) ? req_write_i[i] : sel_write_s;
      sel_addr_s        = (sel_s == PTR_W'(i)) ? req_addr_i[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_wdata_s       = (sel_s == PTR_W'(i)) ? req_wdata_i[i*LINE_W +: LINE_W] : sel_wdata_s;
      grant_onehot_s[i] = (grant_r == PTR_W'(i));
    end
  end

  // Next-state and next-output logic; a write request overrides a simultaneous read.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    mem_read_nxt_s  = mem_read_r;
    mem_write_nxt_s = mem_write_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    rdata_nxt_s     = rdata_r;
    resp_nxt_s      = '0;
`ifdef MEM_ARBITER_RR_EN
    ptr_nxt_s       = ptr_r;
`endif
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_nxt_s     = sel_s;
          mem_write_nxt_s = sel_write_s;
          mem_read_nxt_s  = ~sel_write_s;
          addr_nxt_s      = sel_addr_s;
          wdata_nxt_s     = sel_wdata_s;
`ifdef MEM_ARBITER_RR_EN
          ptr_nxt_s       = (int'(sel_s) + 1 >= N_PORTS) ? '0 : sel_s + PTR_W'(1);
`endif
          state_nxt_s     = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_resp_i) begin
          mem_read_nxt_s  = 1'b0;
          mem_write_nxt_s = 1'b0;
          rdata_nxt_s     = mem_read_r ? mem_rdata_i : rdata_r;
          resp_nxt_s      = grant_onehot_s;
          state_nxt_s     = ACK;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      resp_r      <= '0;
`ifdef MEM_ARBITER_RR_EN
      ptr_r       <= '0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      mem_read_r  <= mem_read_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      rdata_r     <= rdata_nxt_s;
      resp_r      <= resp_nxt_s;
`ifdef MEM_ARBITER_RR_EN
      ptr_r       <= ptr_nxt_s;
`endif
    end
  end

  assign req_rdata_o = rdata_r;
  assign req_resp_o  = resp_r;
  assign mem_read_o  = mem_read_r;
  assign mem_write_o = mem_write_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr (4 ports, 64-bit lines); follows MEM_ARBITER_RR_EN for the grant model.
module tb_mem_arbiter_rr;
  localparam int NP = 4;
  localparam int LW = 64;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_read_i, req_write_i;
  logic [NP*AW-1:0] req_addr_i;
  logic [NP*LW-1:0] req_wdata_i;
  logic [LW-1:0]    req_rdata_o;
  logic [NP-1:0]    req_resp_o;
  logic             mem_read_o, mem_write_o;
  logic [AW-1:0]    mem_addr_o;
  logic [LW-1:0]    mem_wdata_o;
  logic [LW-1:0]    mem_rdata_i;
  logic             mem_resp_i;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.N_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_read_i(req_read_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rdata_o(req_rdata_o), .req_resp_o(req_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
  );

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t          sb_q[$];
  int            checks_cnt = 0;
  int            fail_cnt   = 0;
  logic [NP-1:0] rd_v, wr_v;
  logic [AW-1:0] addr_v [NP];
  logic [LW-1:0] wdata_v [NP];
  int            rem_v [NP];
  int            ptr_m;
  logic [LW-1:0] last_rdata_m;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected grant: first requester searching from ptr_m (round-robin) or from port 0 (fixed).
  function automatic int pick_port();
    logic [NP-1:0] r;
    int idx;
    r = rd_v | wr_v;
    for (int k = 0; k < NP; k++) begin
`ifdef MEM_ARBITER_RR_EN
      idx = (ptr_m + k) % NP;
`else
      idx = k;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic apply_reqs();
    for (int p = 0; p < NP; p++) begin
      req_read_i[p]             = rd_v[p];
      req_write_i[p]            = wr_v[p];
      req_addr_i[p*AW +: AW]    = addr_v[p];
      req_wdata_i[p*LW +: LW]   = wdata_v[p];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_read"}, mem_read_o, 0);
    check_eq({tag, "_mem_write"}, mem_write_o, 0);
    check_eq({tag, "_mem_addr"}, mem_addr_o, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check_eq({tag, "_resp"}, req_resp_o, 0);
    check_eq({tag, "_rdata"}, req_rdata_o, 0);
  endtask

  // One transaction: predict grant, follow it through BUSY/ACK, then retire the port's request.
  task automatic run_txn(input int delay, input logic [LW-1:0] line, output bit ok);
    txn_t t;
    int   g;
    int   waited;
    ok = 1'b0;
    g = pick_port();
    if (g < 0) return;
    t.port = g; t.wr = wr_v[g]; t.addr = addr_v[g]; t.wdata = wdata_v[g]; t.rdata = line;
    sb_q.push_back(t);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(mem_read_o || mem_write_o) && waited < 10);
    check_eq("grant_latency", waited, 1);
    if (!(mem_read_o || mem_write_o)) begin
      sb_q.delete();
      return;
    end
    t = sb_q.pop_front();
    check_eq("mem_write", mem_write_o, t.wr);
    check_eq("mem_read", mem_read_o, !t.wr);
    check_eq("mem_addr", mem_addr_o, t.addr);
    if (t.wr) check_eq("mem_wdata", mem_wdata_o, t.wdata);
    for (int c = 1; c < delay; c++) begin
      req_addr_i[g*AW +: AW] = ~t.addr;
      mem_rdata_i = {$urandom, $urandom};
      @(negedge clk);
      check_eq("op_held", mem_read_o | mem_write_o, 1);
      check_eq("addr_held", mem_addr_o, t.addr);
      check_eq("resp_busy", req_resp_o, 0);
    end
    mem_resp_i  = 1'b1;
    mem_rdata_i = t.rdata;
    @(negedge clk);
    mem_resp_i  = 1'b0;
    mem_rdata_i = {$urandom, $urandom};
    if (!t.wr) last_rdata_m = t.rdata;
    check_eq("resp_pulse", req_resp_o, 64'd1 << g);
    check_eq("op_dropped", mem_read_o | mem_write_o, 0);
    check_eq("rdata", req_rdata_o, last_rdata_m);
    ptr_m = (g + 1) % NP;
    rem_v[g]--;
    if (rem_v[g] <= 0) begin
      rd_v[g] = 1'b0;
      wr_v[g] = 1'b0;
    end else begin
      addr_v[g]  = addr_v[g] + 32'h40;
      wdata_v[g] = {$urandom, $urandom};
    end
    apply_reqs();
    @(negedge clk);
    check_eq("resp_one_cycle", req_resp_o, 0);
    ok = 1'b1;
  endtask

  task automatic run_batch(input int n, input int dmin, input int dmax);
    bit ok;
    for (int i = 0; i < n; i++) begin
      run_txn($urandom_range(dmin, dmax), {$urandom, $urandom}, ok);
      if (!ok) break;
    end
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a, input int n);
    rd_v[p]    = rd;
    wr_v[p]    = wr;
    addr_v[p]  = a;
    wdata_v[p] = {$urandom, $urandom};
    rem_v[p]   = n;
  endtask

  task automatic check_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_eq("idle_no_op", mem_read_o | mem_write_o, 0);
      check_eq("idle_no_resp", req_resp_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int total;
    rst = 1'b1;
    rd_v = '0; wr_v = '0;
    for (int p = 0; p < NP; p++) begin
      addr_v[p] = '0; wdata_v[p] = '0; rem_v[p] = 0;
    end
    ptr_m = 0;
    last_rdata_m = '0;
    mem_resp_i = 1'b0;
    mem_rdata_i = '0;
    apply_reqs();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    check_idle(2);

    // Port 0 read with a 5-cycle downstream latency.
    set_port(0, 1'b1, 1'b0, 32'h0000_1000, 1);
    apply_reqs();
    run_txn(5, {8{8'hA5}}, ok);
    check_eq("rdata_a5", req_rdata_o, {8{8'hA5}});

    // Port 1 asserting read and write is a write; read line must hold.
    set_port(1, 1'b1, 1'b1, 32'h0000_0040, 1);
    wdata_v[1] = 64'h1122_3344_5566_7788;
    apply_reqs();
    run_txn(2, {$urandom, $urandom}, ok);
    check_eq("rdata_hold_after_write", req_rdata_o, {8{8'hA5}});
    check_idle(2);

    // Ports 0 and 1 requesting continuously.
    set_port(0, 1'b1, 1'b0, 32'h0000_2000, 4);
    set_port(1, 1'b0, 1'b1, 32'h0000_3000, 4);
    apply_reqs();
    run_batch(8, 1, 3);
    check_idle(2);

    // Port 2 alone leaves ptr at 3; then ports 1 and 2 together.
    set_port(2, 1'b1, 1'b0, 32'h0000_4000, 1);
    apply_reqs();
    run_batch(1, 1, 2);
    set_port(1, 1'b1, 1'b0, 32'h0000_5000, 1);
    set_port(2, 1'b0, 1'b1, 32'h0000_6000, 1);
    apply_reqs();
    run_batch(2, 1, 2);
    check_idle(2);

    // Random request mixes on all four ports.
    for (int r = 0; r < 4; r++) begin
      logic [NP-1:0] mask;
      int op;
      mask = NP'($urandom_range(1, 15));
      total = 0;
      for (int p = 0; p < NP; p++) begin
        if (mask[p]) begin
          op = $urandom_range(0, 2);
          set_port(p, op != 1, op != 0, $urandom & 32'hFFFF_FFC0, $urandom_range(1, 2));
          total += rem_v[p];
        end
      end
      apply_reqs();
      run_batch(total, 1, 4);
      check_idle(1);
    end

    // Reset asserted mid-BUSY drops the transaction; a stray mem_resp_i is ignored.
    set_port(0, 1'b1, 1'b0, 32'h0000_7000, 1);
    apply_reqs();
    @(negedge clk);
    check_eq("pre_reset_read", mem_read_o, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_busy_rst");
    ptr_m = 0;
    last_rdata_m = '0;
    rd_v = '0; wr_v = '0;
    apply_reqs();
    @(negedge clk);
    rst = 1'b0;
    mem_resp_i = 1'b1;
    mem_rdata_i = {$urandom, $urandom};
    @(negedge clk);
    mem_resp_i = 1'b0;
    check_idle(3);
    check_eq("rdata_after_stray_resp", req_rdata_o, 0);
    set_port(3, 1'b0, 1'b1, 32'h0000_8000, 1);
    apply_reqs();
    run_batch(1, 1, 3);
    check_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
